// File: rtl/hs_tx_arbiter.sv
// hs_tx_arbiter: round-robin arbiter sharing one two-flop handshake synchronizer among NREQ requesters
module hs_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 24,
  parameter int IDW   = 2,
  parameter int TMO_W = 8
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     i_req_valid,
  input  logic [NREQ*DW-1:0]  i_req_data,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic                i_sync_sidle,
  output logic                o_sync_sready,
  output logic [IDW+DW-1:0]   o_sync_din,
  output logic                o_busy,
  output logic [IDW-1:0]      o_grant_id,
  output logic                o_stall_err,
  input  logic                i_stall_clr
);
  typedef enum logic [1:0] {ARB, LAUNCH, WAIT} state_t;
  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW:0]     w_idx;
  logic [DW-1:0]    w_win_data;
  logic [NREQ-1:0]  w_onehot;
  logic             w_grant;
  logic             w_tmo_hit;
  // first pending requester scanning from r_rr_ptr upward with wrap at NREQ-1
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      w_idx = (w_idx >= (IDW+1)'(NREQ)) ? w_idx - (IDW+1)'(NREQ) : w_idx;
      if (!w_found && i_req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end
  // payload and accept mask of the winner
  always_comb begin
    w_win_data = '0;
    w_onehot   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_win_data  = i_req_data[i*DW +: DW];
        w_onehot[i] = 1'b1;
      end
    end
  end
  assign w_grant   = (r_state == ARB) && i_sync_sidle && w_found;
  assign w_tmo_hit = (r_state == WAIT) && !i_sync_sidle && (r_tmo_cnt == ~TMO_W'(1));
  assign o_busy    = (r_state != ARB);
  // grant FSM with registered launch, accept, id and sticky stall flag
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ARB;
      r_rr_ptr      <= '0;
      r_tmo_cnt     <= '0;
      o_sync_sready <= 1'b0;
      o_sync_din    <= '0;
      o_req_ready   <= '0;
      o_grant_id    <= '0;
      o_stall_err   <= 1'b0;
    end else begin
      o_sync_sready <= w_grant;
      o_req_ready   <= w_grant ? w_onehot : '0;
      o_stall_err   <= w_tmo_hit | (o_stall_err & ~i_stall_clr);
      case (r_state)
        ARB: begin
          if (w_grant) begin
            o_sync_din <= {w_win, w_win_data};
            o_grant_id <= w_win;
            r_rr_ptr   <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
            r_state    <= LAUNCH;
          end
        end
        LAUNCH: r_state <= WAIT;
        WAIT: begin
          if (i_sync_sidle) begin
            r_state   <= ARB;
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt != '1) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_hs_tx_arbiter.sv
// tb_hs_tx_arbiter: scoreboard bench for hs_tx_arbiter (NREQ=4 main instance, NREQ=3 wrap instance)
module tb_hs_tx_arbiter;
  localparam int DW = 24, IDW = 2, TMO_W = 4;
  typedef struct packed {
    logic [IDW+DW-1:0] din;
    logic [3:0]        rdy;
    logic [IDW-1:0]    id;
  } exp_t;

  logic sclk = 1'b0;
  logic rst_n = 1'b1;
  always #5 sclk = ~sclk;

  logic [3:0]        req_valid;
  logic [4*DW-1:0]   req_data;
  logic [3:0]        req_ready;
  logic              sidle, sready, busy, stall_err, stall_clr;
  logic [IDW+DW-1:0] din;
  logic [IDW-1:0]    gid;

  logic [2:0]        v3, r3;
  logic [3*DW-1:0]   d3;
  logic              sidle3, sready3, busy3, err3;
  logic [IDW+DW-1:0] din3;
  logic [IDW-1:0]    gid3;

  logic        force_low;
  int          idle_delay;
  int          bcnt, bcnt3;
  int          checks = 0;
  int          failures = 0;
  exp_t        q[$], q3[$];
  exp_t        em, em3;
  logic [DW-1:0] dv[4];

  hs_tx_arbiter #(.NREQ(4), .DW(DW), .IDW(IDW), .TMO_W(TMO_W)) dut (
    .sclk(sclk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_sync_sidle(sidle), .o_sync_sready(sready),
    .o_sync_din(din), .o_busy(busy), .o_grant_id(gid), .o_stall_err(stall_err),
    .i_stall_clr(stall_clr));

  hs_tx_arbiter #(.NREQ(3), .DW(DW), .IDW(IDW), .TMO_W(TMO_W)) dut3 (
    .sclk(sclk), .rst_n(rst_n), .i_req_valid(v3), .i_req_data(d3),
    .o_req_ready(r3), .i_sync_sidle(sidle3), .o_sync_sready(sready3),
    .o_sync_din(din3), .o_busy(busy3), .o_grant_id(gid3), .o_stall_err(err3),
    .i_stall_clr(1'b0));

  // synchronizer models: source side goes busy on launch and returns idle after idle_delay cycles
  always @(posedge sclk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (sready) bcnt <= idle_delay;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  always @(posedge sclk or negedge rst_n)
    if (!rst_n) bcnt3 <= 0;
    else if (sready3) bcnt3 <= idle_delay;
    else if (bcnt3 > 0) bcnt3 <= bcnt3 - 1;
  assign sidle  = !force_low && (bcnt == 0) && !sready;
  assign sidle3 = (bcnt3 == 0) && !sready3;

  // monitors: every launch pops one expected grant
  always @(negedge sclk) if (rst_n) begin
    if (sready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected din=%h ready=%b id=%0d", din, req_ready, gid);
      end else begin
        em = q.pop_front();
        if ({din, req_ready, gid} !== {em.din, em.rdy, em.id}) begin
          failures++;
          $display("FAIL grant din=%h ready=%b id=%0d required din=%h ready=%b id=%0d",
                   din, req_ready, gid, em.din, em.rdy, em.id);
        end
      end
    end else if (req_ready !== 4'b0) begin
      checks++;
      failures++;
      $display("FAIL stray_ready actual=%b required=0000", req_ready);
    end
  end
  always @(negedge sclk) if (rst_n) begin
    if (sready3) begin
      checks++;
      if (q3.size() == 0) begin
        failures++;
        $display("FAIL grant3_unexpected din=%h ready=%b", din3, r3);
      end else begin
        em3 = q3.pop_front();
        if ({din3, 1'b0, r3, gid3} !== {em3.din, em3.rdy, em3.id}) begin
          failures++;
          $display("FAIL grant3 din=%h ready=%b id=%0d required din=%h ready=%b id=%0d",
                   din3, r3, gid3, em3.din, em3.rdy, em3.id);
        end
      end
    end else if (r3 !== 3'b0) begin
      checks++;
      failures++;
      $display("FAIL stray_ready3 actual=%b required=000", r3);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  task automatic push(input int id, input bit to3);
    exp_t e;
    e.din = {IDW'(id), dv[id]};
    e.rdy = 4'b0001 << id;
    e.id  = IDW'(id);
    if (to3) q3.push_back(e);
    else q.push_back(e);
  endtask

  task automatic wait_sready(input string nm, input int maxc);
    int n = 0;
    while (n < maxc) begin
      @(posedge sclk); #1;
      n++;
      if (sready) break;
    end
    chk({nm, "_launch"}, 32'(sready), 32'd1);
  endtask

  task automatic wait_drain(input string nm, input bit on3, input int maxc);
    int n = 0;
    while (((on3 ? q3.size() : q.size()) != 0) && n < maxc) begin
      @(posedge sclk); #2;
      n++;
    end
    chk({nm, "_pending"}, 32'(on3 ? q3.size() : q.size()), 32'd0);
    if (on3) q3.delete();
    else q.delete();
  endtask

  task automatic do_reset();
    @(posedge sclk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    v3 = '0;
    stall_clr = 1'b0;
    force_low = 1'b0;
    idle_delay = 5;
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    dv[0] = 24'h0A0A0A; dv[1] = 24'h1B1B1B; dv[2] = 24'hABCDEF; dv[3] = 24'h3C3C3C;
    req_data = {dv[3], dv[2], dv[1], dv[0]};
    d3 = {dv[2], dv[1], dv[0]};
    req_valid = '0; v3 = '0; stall_clr = 1'b0; force_low = 1'b0; idle_delay = 5;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    chk("rst_sready", 32'(sready), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // single word from requester 2
    @(posedge sclk); #1;
    req_valid = 4'b0100;
    push(2, 1'b0);
    @(posedge sclk); #1;
    chk("single_sready", 32'(sready), 32'd1);
    chk("single_din", 32'(din), {6'd0, 2'd2, 24'hABCDEF});
    chk("single_ready", 32'(req_ready), 32'b0100);
    req_valid = '0;
    @(posedge sclk); #1;
    chk("single_sready_off", 32'(sready), 32'd0);
    chk("single_ready_off", 32'(req_ready), 32'd0);
    chk("single_din_held", 32'(din), {6'd0, 2'd2, 24'hABCDEF});
    chk("single_busy", 32'(busy), 32'd1);
    wait_drain("single", 1'b0, 20);

    // round robin with all four pending
    do_reset();
    @(posedge sclk); #1;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) push(i % 4, 1'b0);
    wait_drain("rr", 1'b0, 200);
    req_valid = '0;
    chk("rr_gid", 32'(gid), 32'd1);

    // wrap with NREQ=3: move pointer to 1, then 101 pending
    do_reset();
    @(posedge sclk); #1;
    v3 = 3'b001;
    push(0, 1'b1);
    wait_drain("wrap_setup", 1'b1, 50);
    v3 = '0;
    repeat (10) @(posedge sclk);
    #1 v3 = 3'b101;
    push(2, 1'b1); push(0, 1'b1); push(2, 1'b1);
    wait_drain("wrap", 1'b1, 100);
    v3 = '0;
    chk("wrap_gid", 32'(gid3), 32'd2);

    // synchronizer busy while in ARB blocks the grant
    do_reset();
    force_low = 1'b1;
    @(posedge sclk); #1;
    req_valid = 4'b0001;
    push(0, 1'b0);
    n = 0;
    repeat (6) begin
      @(posedge sclk); #1;
      if (sready) n++;
    end
    chk("lowidle_nogrant", 32'(n), 32'd0);
    chk("lowidle_busy", 32'(busy), 32'd0);
    force_low = 1'b0;
    @(posedge sclk); #1;
    chk("lowidle_grant", 32'(sready), 32'd1);
    req_valid = '0;
    wait_drain("lowidle", 1'b0, 20);

    // stall timeout, set beats clear, sticky, then clear
    do_reset();
    @(posedge sclk); #1;
    req_valid = 4'b0001;
    push(0, 1'b0);
    wait_sready("stall", 10);
    force_low = 1'b1;
    req_valid = '0;
    repeat (15) @(posedge sclk);
    #1 chk("stall_early", 32'(stall_err), 32'd0);
    stall_clr = 1'b1;
    @(posedge sclk); #1;
    chk("stall_set_wins", 32'(stall_err), 32'd1);
    stall_clr = 1'b0;
    repeat (5) @(posedge sclk);
    #1 chk("stall_hold", 32'(stall_err), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    force_low = 1'b0;
    @(posedge sclk); #1;
    chk("stall_release_busy", 32'(busy), 32'd0);
    chk("stall_sticky", 32'(stall_err), 32'd1);
    stall_clr = 1'b1;
    @(posedge sclk); #1;
    stall_clr = 1'b0;
    chk("stall_cleared", 32'(stall_err), 32'd0);
    wait_drain("stall", 1'b0, 10);

    // reset in the middle of WAIT
    do_reset();
    idle_delay = 10;
    @(posedge sclk); #1;
    req_valid = 4'b0010;
    push(1, 1'b0);
    wait_sready("midrst", 10);
    req_valid = '0;
    repeat (3) @(posedge sclk);
    #1 chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_din", 32'(din), 32'd0);
    chk("midrst_ctl", 32'({req_ready, gid, sready, stall_err, busy}), 32'd0);
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
    idle_delay = 5;
    @(posedge sclk); #1;
    req_valid = 4'b1111;
    q.delete();
    push(0, 1'b0);
    wait_sready("midrst_after", 10);
    req_valid = '0;
    wait_drain("midrst", 1'b0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
